// File: rtl/payload_streamer_if.sv
// Load and output handshake bundle for payload_streamer.
// The master side supplies load tuples and consumes output tuples; the streamer is the slave.
interface payload_streamer_if #(
  parameter int ITEM_WIDTH = 8,
  parameter int CHANNELS   = 2
);
  logic                           load_valid;
  logic                           load_ready;
  logic [CHANNELS*ITEM_WIDTH-1:0] load_data;
  logic                           load_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [CHANNELS*ITEM_WIDTH-1:0] out_data;

  modport master (
    output load_valid, load_data, load_last, out_ready,
    input  load_ready, out_valid, out_data
  );

  modport slave (
    input  load_valid, load_data, load_last, out_ready,
    output load_ready, out_valid, out_data
  );
endinterface

// File: rtl/payload_streamer.sv
// Buffers a batch of multi-channel tuples, then replays the batch REPEAT times
// downstream before returning to idle for the next batch.
module payload_streamer #(
  parameter int NUM        = 100,
  parameter int ITEM_WIDTH = 8,
  parameter int CHANNELS   = 2,
  parameter int REPEAT     = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  payload_streamer_if.slave    bus,
  output logic                 xmit_en_o,
  output logic [15:0]          batch_cnt_o
);

  localparam int W      = CHANNELS * ITEM_WIDTH;
  localparam int PTR_W  = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int REP    = (REPEAT < 1) ? 1 : REPEAT;
  localparam int PASS_W = (REP > 1) ? $clog2(REP) : 1;
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM - 1);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(REP - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SEND
  } state_t;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  last_q, last_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [15:0]       batch_cnt_q, batch_cnt_d;
  logic [W-1:0]      buffer [NUM];
  logic              load_fire;
  logic              out_fire;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_addr;

  assign bus.load_ready = (state_q != SEND);
  assign bus.out_valid  = (state_q == SEND);
  assign bus.out_data   = buffer[rd_ptr_q];
  assign xmit_en_o      = (state_q == IDLE);
  assign batch_cnt_o    = batch_cnt_q;

  assign load_fire = bus.load_valid && (state_q != SEND);
  assign out_fire  = bus.out_ready && (state_q == SEND);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    last_d      = last_q;
    pass_d      = pass_q;
    batch_cnt_d = batch_cnt_q;
    wr_en       = 1'b0;
    wr_addr     = wr_ptr_q;

    case (state_q)
      IDLE: begin
        if (load_fire) begin
          wr_en    = 1'b1;
          wr_addr  = '0;
          wr_ptr_d = PTR_W'(1);
          rd_ptr_d = '0;
          pass_d   = '0;
          if (bus.load_last || (NUM == 1)) begin
            state_d = SEND;
            last_d  = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end

      LOAD: begin
        // A full buffer closes the batch just like an explicit last marker.
        if (load_fire) begin
          wr_en = 1'b1;
          if (bus.load_last || (wr_ptr_q == LAST_IDX)) begin
            state_d = SEND;
            last_d  = wr_ptr_q;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end

      SEND: begin
        if (out_fire) begin
          if (rd_ptr_q == last_q) begin
            rd_ptr_d = '0;
            if (pass_q == LAST_PASS) begin
              state_d     = IDLE;
              pass_d      = '0;
              batch_cnt_d = batch_cnt_q + 16'd1;
            end else begin
              pass_d = pass_q + 1'b1;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_q      <= '0;
      pass_q      <= '0;
      batch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_q      <= last_d;
      pass_q      <= pass_d;
      batch_cnt_q <= batch_cnt_d;
    end
  end

  // Tuple storage survives reset; only the control state is cleared.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      buffer[wr_addr] <= bus.load_data;
    end
  end

endmodule

// File: tb/tb_payload_streamer.sv
// Self-checking bench for payload_streamer: a default instance for batching,
// backpressure, overflow and reset, plus a 4-channel REPEAT=3 instance.
module tb_payload_streamer;

  localparam int NUM = 100;

  logic        clk = 1'b0;
  logic        rst0_n;
  logic        rst1_n;
  logic        xmit0;
  logic        xmit1;
  logic [15:0] bcnt0;
  logic [15:0] bcnt1;

  int vecCount    = 0;
  int missCount   = 0;
  int expBatches0 = 0;

  always #5 clk = ~clk;

  payload_streamer_if #(.ITEM_WIDTH(8), .CHANNELS(2)) bus0 ();
  payload_streamer_if #(.ITEM_WIDTH(8), .CHANNELS(4)) bus1 ();

  payload_streamer dut0 (
    .clk_i       (clk),
    .reset_ni    (rst0_n),
    .bus         (bus0),
    .xmit_en_o   (xmit0),
    .batch_cnt_o (bcnt0)
  );

  payload_streamer #(.NUM(100), .ITEM_WIDTH(8), .CHANNELS(4), .REPEAT(3)) dut1 (
    .clk_i       (clk),
    .reset_ni    (rst1_n),
    .bus         (bus1),
    .xmit_en_o   (xmit1),
    .batch_cnt_o (bcnt1)
  );

  typedef struct {
    int dataMode;
    int nTuples;
    int lastIdx;
    int readyMode;
    int expLen;
  } batchVec_t;

  batchVec_t vecs[5];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Loads one batch into dut0 with downstream stalled, then drains it.
  // dataMode 0: (k,2k)  1: (2k+3,2k+4)  2: random.  readyMode 0: always, 1: toggle, 2: random.
  task automatic applyStimulus(input int dataMode, input int nTuples, input int lastIdx,
                               input int readyMode, input int expLen, input int abortAfter);
    logic [15:0] tup[$];
    int          accepted = 0;
    int          outIdx   = 0;
    int          cyc      = 0;
    int          total;
    int          budget;
    logic        rdy;
    logic        vld;

    for (int k = 1; k <= nTuples; k++) begin
      case (dataMode)
        0:       tup.push_back({8'(2 * k), 8'(k)});
        1:       tup.push_back({8'(2 * k + 4), 8'(2 * k + 3)});
        default: tup.push_back(16'($urandom));
      endcase
    end

    bus0.out_ready = 1'b0;
    for (int i = 0; i < nTuples; i++) begin
      bus0.load_valid = 1'b1;
      bus0.load_data  = tup[i];
      bus0.load_last  = (i == lastIdx);
      checkOutput("load_ready", bus0.load_ready, accepted < expLen);
      checkOutput("xmit_en_load", xmit0, accepted == 0);
      checkOutput("out_valid_load", bus0.out_valid, accepted == expLen);
      stepCycle();
      if (accepted < expLen) accepted++;
    end
    bus0.load_valid = 1'b0;
    bus0.load_last  = 1'b0;
    bus0.load_data  = 16'($urandom);

    checkOutput("first_out_valid", bus0.out_valid, 1'b1);
    checkOutput("first_out_data", bus0.out_data, tup[0]);

    total  = expLen;
    budget = 4 * total + 20;
    while (outIdx < total && budget > 0) begin
      if (abortAfter >= 0 && outIdx == abortAfter) return;
      case (readyMode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus0.out_ready = rdy;
      vld = bus0.out_valid;
      checkOutput("out_valid", vld, 1'b1);
      checkOutput("out_data", bus0.out_data, tup[outIdx % expLen]);
      checkOutput("load_ready_send", bus0.load_ready, 1'b0);
      checkOutput("xmit_en_send", xmit0, 1'b0);
      stepCycle();
      cyc++;
      budget--;
      if (rdy && vld) outIdx++;
    end
    if (outIdx < total) checkOutput("drain_timeout", 64'(outIdx), 64'(total));
    bus0.out_ready = 1'b0;
    expBatches0++;
    checkOutput("xmit_after", xmit0, 1'b1);
    checkOutput("out_valid_after", bus0.out_valid, 1'b0);
    checkOutput("batch_cnt", bcnt0, 16'(expBatches0));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] t0;
    logic [31:0] t1;
    int          n;
    int          lastIdx;
    int          acc;

    vecs[0] = '{0, 100, 99, 0, 100};
    vecs[1] = '{1, 3, 2, 0, 3};
    vecs[2] = '{2, 6, 5, 1, 6};
    vecs[3] = '{0, 105, -1, 0, 100};
    vecs[4] = '{2, 1, 0, 2, 1};

    rst0_n          = 1'b0;
    rst1_n          = 1'b0;
    bus0.load_valid = 1'b0;
    bus0.load_last  = 1'b0;
    bus0.load_data  = '0;
    bus0.out_ready  = 1'b0;
    bus1.load_valid = 1'b0;
    bus1.load_last  = 1'b0;
    bus1.load_data  = '0;
    bus1.out_ready  = 1'b0;

    #2;
    checkOutput("rst_xmit", xmit0, 1'b1);
    checkOutput("rst_load_ready", bus0.load_ready, 1'b1);
    checkOutput("rst_out_valid", bus0.out_valid, 1'b0);
    checkOutput("rst_batch_cnt", bcnt0, 16'd0);
    checkOutput("rst_xmit_r3", xmit1, 1'b1);
    checkOutput("rst_out_valid_r3", bus1.out_valid, 1'b0);
    stepCycle();
    rst0_n = 1'b1;
    rst1_n = 1'b1;

    // Two-tuple batch replayed three times on the 4-channel instance.
    t0 = $urandom;
    t1 = $urandom;
    bus1.out_ready  = 1'b1;
    bus1.load_valid = 1'b1;
    bus1.load_data  = t0;
    bus1.load_last  = 1'b0;
    checkOutput("r3_load_ready", bus1.load_ready, 1'b1);
    stepCycle();
    bus1.load_data = t1;
    bus1.load_last = 1'b1;
    checkOutput("r3_load_ready2", bus1.load_ready, 1'b1);
    stepCycle();
    bus1.load_valid = 1'b0;
    bus1.load_last  = 1'b0;
    for (int j = 0; j < 6; j++) begin
      checkOutput("r3_out_valid", bus1.out_valid, 1'b1);
      checkOutput("r3_out_data", bus1.out_data, (j % 2 == 0) ? t0 : t1);
      stepCycle();
    end
    checkOutput("r3_out_valid_after", bus1.out_valid, 1'b0);
    checkOutput("r3_xmit_after", xmit1, 1'b1);
    checkOutput("r3_batch_cnt", bcnt1, 16'd1);
    bus1.out_ready = 1'b0;

    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].dataMode, vecs[v].nTuples, vecs[v].lastIdx,
                    vecs[v].readyMode, vecs[v].expLen, -1);
    end

    for (int r = 0; r < 6; r++) begin
      if ($urandom_range(0, 2) == 0) begin
        lastIdx = -1;
        n       = $urandom_range(NUM, NUM + 10);
      end else begin
        n       = $urandom_range(1, NUM + 20);
        lastIdx = $urandom_range(0, n - 1);
      end
      acc = (lastIdx >= 0) ? lastIdx + 1 : n;
      if (acc > NUM) acc = NUM;
      applyStimulus(2, n, lastIdx, 2, acc, -1);
    end

    // Abort a stream after 10 outputs; reset must act with no clock edge.
    applyStimulus(0, 100, 99, 0, 100, 10);
    bus0.out_ready = 1'b0;
    rst0_n = 1'b0;
    expBatches0 = 0;
    #1;
    checkOutput("mid_rst_out_valid", bus0.out_valid, 1'b0);
    checkOutput("mid_rst_xmit", xmit0, 1'b1);
    checkOutput("mid_rst_batch_cnt", bcnt0, 16'd0);
    checkOutput("mid_rst_load_ready", bus0.load_ready, 1'b1);
    #1;
    rst0_n = 1'b1;
    applyStimulus(2, 2, 1, 0, 2, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
